// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM status codes and arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side buses of the memory arbiter.
// The master modport is the arbiter's view; slave is the caches-plus-RAM view.
interface mem_arbiter_if;

  logic                     iREN;
  cpu_types_pkg::word_t     iaddr;
  logic                     iwait;
  cpu_types_pkg::word_t     iload;

  logic                     dREN;
  logic                     dWEN;
  cpu_types_pkg::word_t     daddr;
  cpu_types_pkg::word_t     dstore;
  logic                     dwait;
  cpu_types_pkg::word_t     dload;

  logic                     ramREN;
  logic                     ramWEN;
  cpu_types_pkg::word_t     ramaddr;
  cpu_types_pkg::word_t     ramstore;
  cpu_types_pkg::word_t     ramload;
  cpu_types_pkg::ramstate_t ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache word accesses onto one RAM port: dcache first,
// with a bounded dcache streak so a pending fetch is never starved.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  mem_arbiter_if.master    bus,
  output logic [CNT_W-1:0] icount,
  output logic [CNT_W-1:0] dcount,
  output logic             ram_err
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  arb_state_t       state_q, state_d;
  logic [SW-1:0]    streak_q, streak_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic [CNT_W-1:0] dcount_q, dcount_d;
  logic             err_q, err_d;
  logic             dreq;

  assign dreq    = bus.dREN | bus.dWEN;
  assign icount  = icount_q;
  assign dcount  = dcount_q;
  assign ram_err = err_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      streak_q <= '0;
      icount_q <= '0;
      dcount_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      icount_q <= icount_d;
      dcount_q <= dcount_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    icount_d     = icount_q;
    dcount_d     = dcount_q;
    err_d        = err_q;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;

    case (state_q)
      IDLE: begin
        // A fetch that has waited out a full dcache streak wins this slot.
        if (dreq && !(bus.iREN && streak_q == STREAK_MAX)) begin
          state_d = DGRANT;
        end else if (bus.iREN) begin
          state_d = IGRANT;
        end
      end

      DGRANT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (!dreq) begin
          state_d = IDLE;
        end else begin
          bus.ramREN = bus.dREN;
          bus.ramWEN = bus.dWEN;
          if (bus.ramstate == ACCESS) begin
            bus.dwait = 1'b0;
            bus.dload = bus.ramload;
            dcount_d  = dcount_q + 1'b1;
            state_d   = IDLE;
            if (!bus.iREN) begin
              streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
              streak_d = streak_q + SW'(1);
            end
          end else if (bus.ramstate == ERROR) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      IGRANT: begin
        bus.ramaddr = bus.iaddr;
        if (!bus.iREN) begin
          state_d = IDLE;
        end else begin
          bus.ramREN = 1'b1;
          bus.iload  = bus.ramload;
          if (bus.ramstate == ACCESS) begin
            bus.iwait = 1'b0;
            icount_d  = icount_q + 1'b1;
            streak_d  = '0;
            state_d   = IDLE;
          end else if (bus.ramstate == ERROR) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural RAM with programmable
// latency, a load scoreboard, a vector table and multi-cycle corner sequences.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  typedef struct {
    bit    chk;
    word_t data;
  } exp_t;

  typedef struct {
    bit    is_i;
    bit    wr;
    word_t addr;
    word_t wdata;
    int    lat;
    word_t exp;
  } vec_t;

  logic        CLK;
  logic        nRST;
  logic [15:0] icount;
  logic [15:0] dcount;
  logic        ram_err;

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_DSTREAK(4), .CNT_W(16)) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .bus    (bus),
    .icount (icount),
    .dcount (dcount),
    .ram_err(ram_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  exp_t dq[$];
  exp_t iq[$];
  int icnt = 0;
  int dcnt = 0;

  // Behavioural RAM: answers ACCESS after ram_lat BUSY cycles of a held strobe.
  word_t     ram_mem [0:1023];
  logic      ram_ready = 1'b0;
  int        ram_cnt = 0;
  int        ram_lat = 0;
  logic      ovr_en = 1'b0;
  ramstate_t ovr_state = FREE;
  ramstate_t model_state;

  function automatic word_t pattern(input int a);
    return word_t'(32'hC0DE0000 | (a & 32'h0000FFFF));
  endfunction

  assign model_state  = !(bus.ramREN || bus.ramWEN) ? FREE :
                        (ram_cnt >= ram_lat) ? ACCESS : BUSY;
  assign bus.ramstate = ovr_en ? ovr_state : model_state;
  assign bus.ramload  = ram_mem[bus.ramaddr[9:0]];

  always @(posedge CLK) begin
    if (!ram_ready) begin
      for (int k = 0; k < 1024; k++) ram_mem[k] <= pattern(k);
      ram_ready <= 1'b1;
      ram_cnt   <= 0;
    end else begin
      if (bus.ramWEN && bus.ramstate == ACCESS) ram_mem[bus.ramaddr[9:0]] <= bus.ramstore;
      if (!(bus.ramREN || bus.ramWEN) || bus.ramstate == ACCESS || bus.ramstate == ERROR)
        ram_cnt <= 0;
      else
        ram_cnt <= ram_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard: every completing cycle consumes the oldest expected word.
  always @(negedge CLK) begin
    exp_t e;
    if (nRST && !bus.dwait) begin
      if (dq.size() == 0) fail_now("d_unexpected_completion");
      else begin
        e = dq.pop_front();
        if (e.chk) chk("dload", bus.dload, e.data);
      end
    end
    if (nRST && !bus.iwait) begin
      if (iq.size() == 0) fail_now("i_unexpected_completion");
      else begin
        e = iq.pop_front();
        if (e.chk) chk("iload", bus.iload, e.data);
      end
    end
    if (nRST && !bus.dwait && !bus.iwait) fail_now("both_waits_low");
  end

  task automatic wait_done(input bit is_i, output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((is_i ? bus.iwait : bus.dwait) && n < 60);
    chk(is_i ? "i_done_timeout" : "d_done_timeout",
        {31'd0, (is_i ? bus.iwait : bus.dwait)}, 32'd0);
  endtask

  task automatic drop_all();
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    ram_lat = v.lat;
    if (v.is_i) iq.push_back('{chk: 1'b1, data: v.exp});
    else        dq.push_back('{chk: !v.wr, data: v.exp});
    @(posedge CLK); #1;
    if (v.is_i) begin
      bus.iREN  = 1'b1;
      bus.iaddr = v.addr;
    end else begin
      bus.dREN   = !v.wr;
      bus.dWEN   = v.wr;
      bus.daddr  = v.addr;
      bus.dstore = v.wdata;
    end
    wait_done(v.is_i, n);
    chk("latency", n, v.lat + 2);
    chk("ramaddr", bus.ramaddr, v.addr);
    chk("ramWEN", {31'd0, bus.ramWEN}, {31'd0, v.wr});
    chk("ungranted_wait", {31'd0, (v.is_i ? bus.dwait : bus.iwait)}, 32'd1);
    if (v.wr) chk("ramstore", bus.ramstore, v.wdata);
    if (v.is_i) icnt++; else dcnt++;
    @(posedge CLK); #1;
    drop_all();
    @(negedge CLK);
    chk("strobes_after", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
    chk("icount", icount, icnt[15:0]);
    chk("dcount", dcount, dcnt[15:0]);
    $display("[TB] %s %s addr=%h lat=%0d cycles=%0d", v.is_i ? "I" : "D",
             v.wr ? "WR" : "RD", v.addr, v.lat, n);
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    int dn;
    int ic;
    int runs[2];

    vecs[0] = '{is_i: 1'b0, wr: 1'b1, addr: 32'h100, wdata: 32'hDEADBEEF, lat: 1, exp: 32'h0};
    vecs[1] = '{is_i: 1'b0, wr: 1'b0, addr: 32'h100, wdata: 32'h0,        lat: 2, exp: 32'hDEADBEEF};
    vecs[2] = '{is_i: 1'b0, wr: 1'b1, addr: 32'h040, wdata: 32'hCAFEF00D, lat: 0, exp: 32'h0};
    vecs[3] = '{is_i: 1'b0, wr: 1'b0, addr: 32'h040, wdata: 32'h0,        lat: 0, exp: 32'hCAFEF00D};
    vecs[4] = '{is_i: 1'b1, wr: 1'b0, addr: 32'h010, wdata: 32'h0,        lat: 3, exp: 32'hC0DE0010};
    vecs[5] = '{is_i: 1'b1, wr: 1'b0, addr: 32'h040, wdata: 32'h0,        lat: 0, exp: 32'hCAFEF00D};
    vecs[6] = '{is_i: 1'b0, wr: 1'b1, addr: 32'h3FF, wdata: 32'h0,        lat: 4, exp: 32'h0};
    vecs[7] = '{is_i: 1'b1, wr: 1'b0, addr: 32'h3FF, wdata: 32'h0,        lat: 1, exp: 32'h0};

    drop_all();
    bus.iaddr  = '0;
    bus.daddr  = '0;
    bus.dstore = '0;
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_iwait", {31'd0, bus.iwait}, 32'd1);
    chk("rst_dwait", {31'd0, bus.dwait}, 32'd1);
    chk("rst_strobes", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
    chk("rst_ramaddr", bus.ramaddr, 32'd0);
    chk("rst_ramstore", bus.ramstore, 32'd0);
    chk("rst_loads", bus.iload | bus.dload, 32'd0);
    chk("rst_counts", {icount, dcount}, 32'd0);
    chk("rst_ram_err", {31'd0, ram_err}, 32'd0);
    nRST = 1'b1;

    // Reset while the dcache access is still BUSY.
    ram_lat = 5;
    @(posedge CLK); #1;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h100;
    @(posedge CLK); @(posedge CLK); #2;
    chk("mid_busy_ramREN", {31'd0, bus.ramREN}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("mid_rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("mid_rst_dwait", {31'd0, bus.dwait}, 32'd1);
    chk("mid_rst_ramaddr", bus.ramaddr, 32'd0);
    chk("mid_rst_dcount", {16'd0, dcount}, 32'd0);
    drop_all();
    @(negedge CLK);
    nRST = 1'b1;
    $display("[TB] reset mid-DGRANT done");

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    chk("no_err_yet", {31'd0, ram_err}, 32'd0);

    // Simultaneous dcache write and icache read: dcache first, one dead cycle, then icache.
    ram_lat = 1;
    dq.push_back('{chk: 1'b0, data: 32'h0});
    iq.push_back('{chk: 1'b1, data: pattern(32'h300)});
    @(posedge CLK); #1;
    bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'h12345678;
    bus.iREN = 1'b1; bus.iaddr = 32'h300;
    wait_done(1'b0, n);
    chk("both_d_latency", n, 32'd3);
    chk("both_iwait_high", {31'd0, bus.iwait}, 32'd1);
    chk("both_ramstore", bus.ramstore, 32'h12345678);
    chk("both_ramWEN", {31'd0, bus.ramWEN}, 32'd1);
    dcnt++;
    @(posedge CLK); #1;
    bus.dWEN = 1'b0;
    wait_done(1'b1, n);
    chk("both_i_latency", n, 32'd3);
    icnt++;
    @(posedge CLK); #1;
    drop_all();
    $display("[TB] D WR + I RD together, i completed %0d cycles after d", n);
    run_vec('{is_i: 1'b0, wr: 1'b0, addr: 32'h200, wdata: 32'h0, lat: 0, exp: 32'h12345678});

    // Fairness: with both held, expect four dcache grants between icache grants.
    ram_lat = 0;
    for (int k = 0; k < 8; k++) dq.push_back('{chk: 1'b1, data: pattern(32'h50)});
    for (int k = 0; k < 2; k++) iq.push_back('{chk: 1'b1, data: pattern(32'h60)});
    @(posedge CLK); #1;
    bus.dREN = 1'b1; bus.daddr = 32'h50;
    bus.iREN = 1'b1; bus.iaddr = 32'h60;
    dn = 0; ic = 0; runs[0] = 0; runs[1] = 0;
    for (int c = 0; c < 100 && ic < 2; c++) begin
      @(negedge CLK);
      if (!bus.dwait) dn++;
      if (!bus.iwait) begin
        runs[ic] = dn;
        ic++;
        dn = 0;
      end
    end
    @(posedge CLK); #1;
    drop_all();
    chk("streak_i_grants", ic, 32'd2);
    chk("streak_run0", runs[0], 32'd4);
    chk("streak_run1", runs[1], 32'd4);
    dcnt += 8; icnt += 2;
    @(negedge CLK);
    chk("streak_dcount", dcount, dcnt[15:0]);
    $display("[TB] streak runs %0d, %0d", runs[0], runs[1]);

    // ERROR during an icache grant, then a retry that completes.
    ram_lat = 3;
    iq.push_back('{chk: 1'b1, data: pattern(32'h30)});
    @(posedge CLK); #1;
    bus.iREN = 1'b1; bus.iaddr = 32'h30;
    n = 0;
    do begin @(negedge CLK); n++; end while (!bus.ramREN && n < 20);
    chk("err_granted", {31'd0, bus.ramREN}, 32'd1);
    @(posedge CLK); #1;
    ovr_en = 1'b1; ovr_state = ERROR;
    @(negedge CLK);
    chk("err_iwait", {31'd0, bus.iwait}, 32'd1);
    @(posedge CLK); #1;
    ovr_en = 1'b0;
    @(negedge CLK);
    chk("err_flag", {31'd0, ram_err}, 32'd1);
    chk("err_back_idle", {31'd0, bus.ramREN}, 32'd0);
    wait_done(1'b1, n);
    icnt++;
    @(posedge CLK); #1;
    drop_all();
    @(negedge CLK);
    chk("err_icount", icount, icnt[15:0]);
    $display("[TB] I RD with ERROR retried, done after %0d cycles", n);

    // Dcache request withdrawn while BUSY.
    ram_lat = 5;
    @(posedge CLK); #1;
    bus.dREN = 1'b1; bus.daddr = 32'h80;
    n = 0;
    do begin @(negedge CLK); n++; end while (!bus.ramREN && n < 20);
    chk("abort_granted", {31'd0, bus.ramREN}, 32'd1);
    @(posedge CLK); #1;
    bus.dREN = 1'b0;
    @(negedge CLK);
    chk("abort_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("abort_dwait", {31'd0, bus.dwait}, 32'd1);
    @(negedge CLK);
    chk("abort_dcount", dcount, dcnt[15:0]);
    $display("[TB] D RD aborted while BUSY");
    run_vec('{is_i: 1'b1, wr: 1'b0, addr: 32'h80, wdata: 32'h0, lat: 2, exp: pattern(32'h80)});

    chk("err_sticky", {31'd0, ram_err}, 32'd1);
    chk("dq_drained", dq.size(), 32'd0);
    chk("iq_drained", iq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Downstream neighbour of the data cache. Arbitrates the icache and dcache miss/writeback traffic onto the single-ported RAM.
- Holds each grant until the RAM finishes the word access, then releases the requester's wait.
- Gives dcache priority, with a bounded-streak fairness rule so fetch cannot starve.
- Keeps completed-access counters and an error flag for the halt/statistics path.

Parameters:
- MAX_DSTREAK, 4: maximum consecutive dcache grants while iREN is pending; after this many, icache gets the next grant.
- CNT_W, 16: width of the access counters.

Ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  low for exactly the completing cycle of an icache access
- iload  out  32  instruction word; valid when iwait is low
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request (dWEN and dREN are never both high)
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  low for exactly the completing cycle of a dcache access
- dload  out  32  data word; valid when dwait is low
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- icount  out  CNT_W  completed icache accesses (wraps)
- dcount  out  CNT_W  completed dcache accesses (wraps)
- ram_err  out  1  sticky; set on any ERROR

Behaviour:
- Clock and reset are fixed: one clock, CLK; reset nRST is asynchronous and active-low.
- Reset values: state IDLE, streak 0, icount 0, dcount 0, ram_err 0.
- Reset output levels: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
- A reset mid-access abandons the access; no counter is updated.
- FSM has three states: IDLE, DGRANT, IGRANT.
- IDLE:
  - Drives no RAM strobes; both waits are high.
  - Goes to DGRANT if (dREN|dWEN) and not (iREN and streak==MAX_DSTREAK).
  - Otherwise goes to IGRANT if iREN. Otherwise stays in IDLE.
  - Every grant is preceded by one dead IDLE cycle.
- DGRANT:
  - ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - dwait=1 unless ramstate==ACCESS, in which case dwait=0 and dload=ramload that same cycle (combinational), then go to IDLE.
- IGRANT:
  - ramREN=1, ramWEN=0, ramaddr=iaddr.
  - iwait=(ramstate!=ACCESS) and iload=ramload, then go to IDLE on ACCESS.
- Abort: if the granted request drops (dREN|dWEN low in DGRANT, or iREN low in IGRANT) before ACCESS, deassert the strobes that cycle and return to IDLE. No count, no wait release.
- ERROR while granted:
  - Wait stays high; go to IDLE; ram_err<=1.
  - The requester stays pending and is re-arbitrated.
- Streak counter:
  - On a dcache completion with iREN high, streak<=min(streak+1, MAX_DSTREAK).
  - On an icache completion, streak<=0.
  - On a dcache completion with iREN low, streak<=0.
- Counters: increment only on the ACCESS cycle of the owning grant; plain wrap at 2^CNT_W.
- The ungranted requester's wait is held high at all times.
- Address and data are passed through unregistered while granted. Requesters hold them stable until wait drops.

Decomposition:
- Shared package cpu_types_pkg gets the ramstate_t enum (FREE, BUSY, ACCESS, ERROR) and the arbiter state enum arb_state_t.
- word_t comes from the same package.
- Single module, no sub-module. Counters and streak logic are inline.

Test Plan:
- Reset mid-DGRANT while ramstate=BUSY -> all outputs at reset values immediately; dcount stays 0.
- dREN only, addr 0x100, RAM returns 0xDEADBEEF after 2 BUSY cycles -> dwait low for one cycle with dload=0xDEADBEEF; dcount=1; ramREN low in the next cycle.
- iREN and dWEN raised together, dstore=0x12345678 -> dcache granted first; the RAM write is observed; icache granted after one IDLE cycle; iwait held high throughout.
- MAX_DSTREAK=4, dREN held continuously, iREN high -> exactly 4 dcache completions, then an icache grant; streak returns to 0.
- ramstate=ERROR during IGRANT -> iwait stays high; ram_err=1 and sticky; icache re-granted and completes on a later ACCESS with icount=1.
- dREN dropped while DGRANT and BUSY -> ramREN=0 that cycle; FSM returns to IDLE; dcount unchanged.
